// File: rtl/pipe_mux_pkg.sv
// Shared types and defaults for the registered N:1 pipeline selector.
package pipe_mux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;

  // Default-width view of one held entry.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic                 err;
    logic                 valid;
  } entry_t;

  // Encoded as {S.valid, M.valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 selector; out-of-range selects give zero data and flag err.
module mux_nto1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   mux,
  output logic               err
);

  logic [31:0] sel_ext;

  always_comb begin
    sel_ext = 32'(sel);
    mux     = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_ext == 32'(k)) mux = in_data[k*WIDTH +: WIDTH];
    end
    err = (sel_ext >= 32'(N));
  end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N:1 selector with a main output register and a one-entry skid buffer.
//   state | meaning
//   EMPTY | nothing held
//   ONE   | M holds the output entry, S free
//   FULL  | M and S both hold entries, in_ready low
module pipe_mux_reg
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               sel_err,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
    logic             valid;
  } slot_t;

  slot_t            m_q, m_d;
  slot_t            s_q, s_d;
  slot_t            new_e;
  state_t           state;
  logic [WIDTH-1:0] mux;
  logic             mux_err;
  logic             xfer_in;
  logic             xfer_out;

  mux_nto1 #(
    .WIDTH (WIDTH),
    .N     (N),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .mux     (mux),
    .err     (mux_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  always_comb begin
    m_d      = m_q;
    s_d      = s_q;
    new_e    = '{data: mux, err: mux_err, valid: 1'b1};
    xfer_in  = in_valid && in_ready;
    xfer_out = out_valid && out_ready;
    state    = m_q.valid ? (s_q.valid ? FULL : ONE) : EMPTY;

    // Flush drops validity only; the data fields keep their last loaded value.
    if (flush) begin
      m_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) m_d = new_e;
        end
        ONE: begin
          if (xfer_out && xfer_in) m_d = new_e;
          else if (xfer_out)       m_d.valid = 1'b0;
          else if (xfer_in)        s_d = new_e;
        end
        FULL: begin
          if (xfer_out) begin
            m_d       = s_q;
            s_d.valid = 1'b0;
          end
        end
        default: begin
          m_d.valid = 1'b0;
          s_d.valid = 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = !s_q.valid;
  assign out_valid = m_q.valid;
  assign out_data  = m_q.data;
  assign sel_err   = m_q.err && m_q.valid;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Directed bench for pipe_mux_reg: scoreboard-checked N=4 instance plus an N=3 instance for out-of-range select.
module tb_pipe_mux_reg;
  import pipe_mux_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [1:0]     sel;
  logic           in_valid, flush, out_ready;
  logic           in_ready, out_valid, sel_err;
  logic [W-1:0]   out_data;

  logic [3*W-1:0] in_data3;
  logic [1:0]     sel3;
  logic           in_valid3, flush3, out_ready3;
  logic           in_ready3, out_valid3, sel_err3;
  logic [W-1:0]   out_data3;

  int checks = 0;
  int errors = 0;
  entry_t exp_q[$];
  logic [W-1:0] words [4];

  pipe_mux_reg #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .sel_err(sel_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  pipe_mux_reg #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .sel_err(sel_err3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the next cycle's inputs already driven.
  task automatic tick();
    entry_t e;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL scoreboard_underflow observed=%h expected=no_output", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_out_data", out_data, e.data);
        chk("sb_sel_err", W'(sel_err), W'(e.err));
      end
    end
    if (in_valid && in_ready && !flush) begin
      e.data  = words[sel];
      e.err   = 1'b0;
      e.valid = 1'b1;
      exp_q.push_back(e);
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    in_data  = {words[3], words[2], words[1], words[0]};
    in_data3 = {words[2], words[1], words[0]};
    sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sel3 = 2'd0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;

    #12;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_sel_err", W'(sel_err), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Out-of-range select on the N=3 instance
    sel3 = 2'd3; in_valid3 = 1'b1;
    tick();
    chk("oor_out_valid", W'(out_valid3), W'(1));
    chk("oor_out_data", out_data3, '0);
    chk("oor_sel_err", W'(sel_err3), W'(1));
    sel3 = 2'd1;
    tick();
    chk("inr_out_data", out_data3, 32'h22222222);
    chk("inr_sel_err", W'(sel_err3), '0);
    in_valid3 = 1'b0;
    tick();
    chk("oor_drain_valid", W'(out_valid3), '0);
    chk("oor_drain_err", W'(sel_err3), '0);

    // Basic select, one-cycle latency
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("basic_out_valid", W'(out_valid), W'(1));
    chk("basic_out_data", out_data, 32'h33333333);
    chk("basic_sel_err", W'(sel_err), '0);
    tick();

    // Streaming at full rate
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); in_valid = 1'b1;
      chk("stream_in_ready", W'(in_ready), W'(1));
      tick();
      chk("stream_out_valid", W'(out_valid), W'(1));
      chk("stream_out_data", out_data, words[i]);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_idle", W'(out_valid), '0);

    // Back-pressure into the skid register
    out_ready = 1'b0;
    sel = 2'd0; in_valid = 1'b1;
    tick();
    sel = 2'd1;
    tick();
    chk("bp_in_ready_low", W'(in_ready), '0);
    sel = 2'd3;
    tick();
    chk("bp_hold_data", out_data, 32'h11111111);
    chk("bp_still_full", W'(in_ready), '0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_second", out_data, 32'h22222222);
    tick();
    chk("bp_drained", W'(out_valid), '0);
    chk("bp_in_ready_back", W'(in_ready), W'(1));

    // Flush in FULL with an offered input
    out_ready = 1'b0;
    sel = 2'd1; in_valid = 1'b1;
    tick();
    sel = 2'd2;
    tick();
    sel = 2'd3; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", W'(out_valid), '0);
    chk("flush_in_ready", W'(in_ready), W'(1));

    // Flush in ONE with transfer-out and an accepted-looking input
    sel = 2'd0; in_valid = 1'b1;
    tick();
    out_ready = 1'b1; flush = 1'b1; sel = 2'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", W'(out_valid), '0);
    tick();
    chk("flush1_stays_empty", W'(out_valid), '0);

    // Asynchronous reset in FULL
    out_ready = 1'b0;
    sel = 2'd2; in_valid = 1'b1;
    tick();
    sel = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", W'(in_ready), '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", W'(out_valid), '0);
    chk("arst_out_data", out_data, '0);
    chk("arst_sel_err", W'(sel_err), '0);
    chk("arst_in_ready", W'(in_ready), W'(1));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", W'(out_valid), W'(1));
    chk("post_rst_data", out_data, 32'h44444444);
    tick();
    tick();

    chk("sb_empty", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
